// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths and bus field positions for the MEM stage of
// the LoongArch-subset pipeline.
//   DATA_W          : datapath word width (alu_result, pc, SRAM data)
//   EX_MA_W         : width of ex_to_ma_bus
//   MA_WB_W         : width of ma_to_wb_bus
//   MA_ID_W         : width of ma_to_id_bus (hazard bus to ID)
//   EX_* / WB_*     : bit positions of the fields inside the two buses
package mem_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int EX_MA_W = 71;
  localparam int MA_WB_W = 70;
  localparam int MA_ID_W = 6;

  // ex_to_ma_bus = {res_from_mem, gr_we, dest, alu_result, pc}
  localparam int EX_RFM_BIT = 70;
  localparam int EX_WE_BIT  = 69;
  localparam int EX_DEST_HI = 68;
  localparam int EX_DEST_LO = 64;
  localparam int EX_ALU_HI  = 63;
  localparam int EX_ALU_LO  = 32;
  localparam int EX_PC_HI   = 31;
  localparam int EX_PC_LO   = 0;

  // ma_to_wb_bus = {gr_we, dest, final_result, pc}
  localparam int WB_WE_BIT  = 69;
  localparam int WB_DEST_HI = 68;
  localparam int WB_DEST_LO = 64;
  localparam int WB_RES_HI  = 63;
  localparam int WB_RES_LO  = 32;
  localparam int WB_PC_HI   = 31;
  localparam int WB_PC_LO   = 0;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: handshake and data buses around the MEM stage.
//   ex_validout     : EX holds a valid instruction for MEM
//   wb_allowin      : WB can accept this cycle
//   ma_allowin      : MEM can accept from EX this cycle
//   ma_validout     : MEM presents a valid instruction to WB
//   ex_to_ma_bus    : instruction payload from EX
//   data_sram_rdata : synchronous data SRAM read response
//   ma_to_wb_bus    : payload to WB
//   ma_to_id_bus    : {gr_we, dest} hazard info to ID, zero in a bubble
// Modport slave is the MEM stage itself; master is its environment.
interface mem_stage_if
  import mem_stage_pkg::*;
();

  logic               ex_validout;
  logic               wb_allowin;
  logic               ma_allowin;
  logic               ma_validout;
  logic [EX_MA_W-1:0] ex_to_ma_bus;
  logic [DATA_W-1:0]  data_sram_rdata;
  logic [MA_WB_W-1:0] ma_to_wb_bus;
  logic [MA_ID_W-1:0] ma_to_id_bus;

  modport slave (
    input  ex_validout, wb_allowin, ex_to_ma_bus, data_sram_rdata,
    output ma_allowin, ma_validout, ma_to_wb_bus, ma_to_id_bus
  );

  modport master (
    output ex_validout, wb_allowin, ex_to_ma_bus, data_sram_rdata,
    input  ma_allowin, ma_validout, ma_to_wb_bus, ma_to_id_bus
  );

endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage pipeline. Registers the EX payload,
// merges in the SRAM read data for loads, and forwards the result to WB.
// Load data is captured into a hold register the first time WB stalls the
// instruction, so the result stays stable while the SRAM output moves on.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   mif  : mem_stage_if.slave (EX/WB handshake, buses, SRAM read data)
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mem_stage_if.slave   mif
);

  logic               r_vld_p1;
  logic               r_held_p1;
  logic [EX_MA_W-1:0] r_bus_p1;
  logic [DATA_W-1:0]  r_rdata_hold_p1;

  logic               w_allowin;
  logic               w_rfm;
  logic               w_we;
  logic [4:0]         w_dest;
  logic [DATA_W-1:0]  w_alu;
  logic [DATA_W-1:0]  w_pc;
  logic [DATA_W-1:0]  w_final;

  // Load result: the held copy wins once captured; before that the SRAM
  // output is still presenting this instruction's data.
  function automatic logic [DATA_W-1:0] sel_result(
    input logic              rfm,
    input logic              held,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] hold,
    input logic [DATA_W-1:0] rdata
  );
    if (!rfm)
      sel_result = alu;
    else if (held)
      sel_result = hold;
    else
      sel_result = rdata;
  endfunction

  // SRAM latency is fixed at one cycle, so MEM is always ready to go.
  assign w_allowin = ~r_vld_p1 | mif.wb_allowin;

  // ---- EX -> MEM register (p1) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1        <= 1'b0;
      r_held_p1       <= 1'b0;
      r_bus_p1        <= '0;
      r_rdata_hold_p1 <= '0;
    end else begin
      if (w_allowin)
        r_vld_p1 <= mif.ex_validout;
      // Capture and hold are exclusive: capture needs allowin, hold needs
      // a valid instruction stalled by WB (allowin low).
      if (mif.ex_validout && w_allowin) begin
        r_bus_p1  <= mif.ex_to_ma_bus;
        r_held_p1 <= 1'b0;
      end else if (r_vld_p1 && !r_held_p1 && !mif.wb_allowin) begin
        r_rdata_hold_p1 <= mif.data_sram_rdata;
        r_held_p1       <= 1'b1;
      end
    end
  end

  assign w_rfm   = r_bus_p1[EX_RFM_BIT];
  assign w_we    = r_bus_p1[EX_WE_BIT];
  assign w_dest  = r_bus_p1[EX_DEST_HI:EX_DEST_LO];
  assign w_alu   = r_bus_p1[EX_ALU_HI:EX_ALU_LO];
  assign w_pc    = r_bus_p1[EX_PC_HI:EX_PC_LO];
  assign w_final = sel_result(w_rfm, r_held_p1, w_alu, r_rdata_hold_p1,
                              mif.data_sram_rdata);

  // ---- MEM -> WB outputs (combinational from p1) ----
  assign mif.ma_allowin                          = w_allowin;
  assign mif.ma_validout                         = r_vld_p1;
  assign mif.ma_to_wb_bus[WB_WE_BIT]             = w_we;
  assign mif.ma_to_wb_bus[WB_DEST_HI:WB_DEST_LO] = w_dest;
  assign mif.ma_to_wb_bus[WB_RES_HI:WB_RES_LO]   = w_final;
  assign mif.ma_to_wb_bus[WB_PC_HI:WB_PC_LO]     = w_pc;
  assign mif.ma_to_id_bus = {w_we & r_vld_p1, w_dest & {5{r_vld_p1}}};

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage LoongArch-subset pipeline. It is the receiving end of the EX->MEM valid/allowin handshake and of ex_to_ma_bus.
- Consumes the synchronous data SRAM read response for the access EX issued one cycle earlier.
- Selects load data or ALU result, then drives ma_to_wb_bus to WB and a hazard bus {gr_we, dest} to ID.
- Holds load data stable across WB back-pressure.

Parameters:
- EX_MA_W, 71, width of ex_to_ma_bus.
- MA_WB_W, 70, width of ma_to_wb_bus.
- MA_ID_W, 6, width of ma_to_id_bus.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- ex_validout  input  1  EX holds a valid instruction for MEM
- wb_allowin  input  1  WB can accept this cycle
- ma_allowin  output  1  MEM can accept from EX this cycle
- ma_validout  output  1  MEM presents a valid instruction to WB
- ex_to_ma_bus  input  71  {res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- data_sram_rdata  input  32  SRAM read data; valid in the cycle after EX drove the address
- ma_to_wb_bus  output  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- ma_to_id_bus  output  6  {gr_we & valid, dest & {5{valid}}}

Behaviour:
- State:
  - valid
  - bus_r[70:0]
  - rdata_hold[31:0]
  - held flag (rdata_hold contains this instruction's load data)
- Reset (rst=1 at posedge):
  - valid=0, bus_r=0, rdata_hold=0, held=0.
  - Consequently ma_validout=0, ma_to_id_bus=6'b0, ma_allowin=1, ma_to_wb_bus={70{0}}.
- readygo=1 (SRAM has fixed 1-cycle latency). ma_allowin = ~valid | wb_allowin. ma_validout = valid.
- Valid update: if ma_allowin, valid <= ex_validout; otherwise valid holds.
- Capture: if ex_validout & ma_allowin, bus_r <= ex_to_ma_bus and held <= 0. Otherwise bus_r holds.
- Load hold:
  - If valid & ~held & ~wb_allowin: rdata_hold <= data_sram_rdata, held <= 1.
  - Hence the SRAM value is sampled exactly in the instruction's first MEM cycle.
- final_result:
  - res_from_mem=0: alu_result.
  - res_from_mem=1, held=1: rdata_hold.
  - res_from_mem=1, held=0: data_sram_rdata.
- Non-load instructions ignore data_sram_rdata. The hold register may still update; this is harmless.
- Bubble (valid=0):
  - ma_to_id_bus is forced to 0.
  - ma_to_wb_bus content is don't-care; WB qualifies it with ma_validout.
- Simultaneous events:
  - Leave and enter in the same cycle (valid & wb_allowin & ex_validout): the new instruction is captured, held cleared.
  - Leave with no new input: valid <= 0.
- Stall (valid & ~wb_allowin):
  - ma_allowin=0; bus_r, valid and final_result are all stable until wb_allowin rises.
- rst asserted mid-stall: the in-flight instruction is dropped with no write-back. After reset, the first accepted instruction behaves as from power-up.
- Latency:
  - 1 cycle EX->MEM register.
  - Combinational from registered state (plus rdata) to the WB bus.
  - No combinational path from ex_* inputs to any output except through ma_allowin's dependence on wb_allowin.

Decomposition:
- Shared package (alongside existing pipeline widths):
  - EX_MA_W, MA_WB_W, MA_ID_W.
  - Field bit positions for ex_to_ma_bus and ma_to_wb_bus.
- No sub-module needed. The load-data hold register plus mux is small enough to stay inline; if factored out, name it mem_rdata_hold.

Test Plan:
- Reset: hold rst=1 for 2 cycles, ex_validout=1 -> ma_validout=0, ma_to_id_bus=0, ma_allowin=1. First post-reset accept appears in the next cycle.
- ALU pass-through: accept bus {0,1,5'd3,32'h0000_0010,32'h1c00_0004}, wb_allowin=1 -> next cycle ma_to_wb_bus={1,3,32'h10,32'h1c000004}, ma_to_id_bus=6'b100011, ma_validout=1.
- Load: accept res_from_mem=1, dest=4; next cycle rdata=32'hdead_beef -> final_result=32'hdeadbeef.
- Load under stall: in the first MEM cycle rdata=32'hdeadbeef with wb_allowin=0 for 3 cycles while rdata changes to 32'h1234_5678 -> final_result stays 32'hdeadbeef, ma_allowin=0 throughout. Releasing wb_allowin hands it to WB.
- Back-to-back: ex_validout=1, wb_allowin=1 every cycle, 4 instructions with pc 0x1c000000..0x1c00000c -> four consecutive ma_validout cycles in order, no bubbles or duplicates.
- Bubble / mid-op reset: ex_validout=0 after one accept -> valid drops after WB takes it, ma_to_id_bus=0. A separate run asserts rst during a stalled load -> ma_validout=0 the next cycle and held=0.
